divclk_edge_monitor: RTL and testbench

Sits directly downstream of the clock divider in the lock-in reference path. It samples the divided clock as a data signal in the fast `clock_in` domain and emits single-cycle rise/fall enable strobes, so downstream logic never clocks off the divided net. It also measures the divided-clock period in `clock_in` cycles and declares lock once that period matches the programmed divisor.

---
 rtl/divclk_edge_monitor.sv | 149 ++++++++++++++
 tb/tb_divclk_edge_monitor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divclk_edge_monitor.sv
// Samples a divided clock as data in the clock_in domain, emits rise/fall enable
// strobes, measures the rise-to-rise period and tracks lock against the programmed divisor.
//
// state   | meaning
// SEARCH  | waiting for the first rise; no period reference yet
// MEASURE | measuring periods, counting consecutive matches toward lock
// LOCKED  | period stable and matching the programmed divisor
module divclk_edge_monitor #(
  parameter int SYNC_STAGES  = 2,
  parameter int PERIOD_W     = 16,
  parameter int STABLE_COUNT = 4
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                div_clk_in,
  input  logic [PERIOD_W-1:0] expected_period,
  output logic                tick_rise,
  output logic                tick_fall,
  output logic [PERIOD_W-1:0] period_meas,
  output logic                period_valid,
  output logic                locked,
  output logic                period_error,
  output logic                bypass,
  output logic [31:0]         rise_count
);

  localparam int                  MATCH_W  = $clog2(STABLE_COUNT + 1);
  localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam logic [PERIOD_W:0]   DIFF_ONE = (PERIOD_W + 1)'(1);
  localparam logic [PERIOD_W:0]   DIFF_NEG = '1;
  localparam logic [MATCH_W-1:0]  MATCH_LAST = MATCH_W'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic                 synced, rise_raw, fall_raw;
  logic [PERIOD_W-1:0]  exp_reg;
  logic [PERIOD_W-1:0]  cnt_q;
  logic [PERIOD_W:0]    diff;
  logic                 match, timeout;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic                 valid_d, err_d, err_q;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise_raw = synced & ~hist_q;
  assign fall_raw = ~synced & hist_q;

  // Unsigned difference one bit wider so +1 and -1 are both visible without wrap ambiguity.
  assign diff    = {1'b0, cnt_q} - {1'b0, exp_reg};
  assign match   = (diff == '0) || (diff == DIFF_ONE) || (diff == DIFF_NEG);
  assign timeout = ~bypass & ~rise_raw & (cnt_q == CNT_MAX);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      exp_reg <= '0;
      bypass  <= 1'b0;
      cnt_q   <= CNT_ONE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      hist_q  <= synced;
      exp_reg <= expected_period;
      bypass  <= (exp_reg <= CNT_ONE);
      if (bypass || rise_raw) begin
        cnt_q <= CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bypass) begin
      state_d = SEARCH;
      match_d = '0;
    end else if (rise_raw) begin
      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          match_d = '0;
        end
        MEASURE: begin
          valid_d = 1'b1;
          if (!match) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          valid_d = 1'b1;
          if (!match) begin
            state_d = MEASURE;
            match_d = '0;
            err_d   = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if (timeout && (state_q != SEARCH)) begin
      state_d = SEARCH;
      match_d = '0;
      err_d   = 1'b1;
    end
  end

  // Error is held one extra flop so it lines up with the registered lock flag.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      match_q      <= '0;
      err_q        <= 1'b0;
      tick_rise    <= 1'b0;
      tick_fall    <= 1'b0;
      period_valid <= 1'b0;
      period_meas  <= '0;
      period_error <= 1'b0;
      locked       <= 1'b0;
      rise_count   <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      err_q        <= err_d;
      tick_rise    <= rise_raw & ~bypass;
      tick_fall    <= fall_raw & ~bypass;
      period_valid <= valid_d;
      if (valid_d) begin
        period_meas <= cnt_q;
      end
      period_error <= err_q & ~bypass;
      locked       <= (state_q == LOCKED);
      if (rise_raw && !bypass) begin
        rise_count <= rise_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_divclk_edge_monitor.sv
// Directed bench for divclk_edge_monitor: lock, tolerance, timeout, bypass,
// mid-lock reset and rise counter wrap, with expected values computed here.
module tb_divclk_edge_monitor;
  localparam int PW = 8;

  logic          clock_in = 1'b0;
  logic          reset_n = 1'b0;
  logic          div_clk_in = 1'b0;
  logic [PW-1:0] expected_period = '0;
  logic          tick_rise, tick_fall, period_valid, locked, period_error, bypass;
  logic [PW-1:0] period_meas;
  logic [31:0]   rise_count;

  always #5 clock_in = ~clock_in;

  divclk_edge_monitor #(.SYNC_STAGES(2), .PERIOD_W(PW), .STABLE_COUNT(4)) dut (
    .clock_in(clock_in),
    .reset_n(reset_n),
    .div_clk_in(div_clk_in),
    .expected_period(expected_period),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall),
    .period_meas(period_meas),
    .period_valid(period_valid),
    .locked(locked),
    .period_error(period_error),
    .bypass(bypass),
    .rise_count(rise_count)
  );

  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  bit   check_meas = 1'b1;
  int   n_valid, n_err, n_rise, n_fall, n_strobe, n_unlocked, n_nobypass;
  int   valid_since_err, lock_valids;
  logic lock_after_valid, lock_fall_err, prev_locked, prev_valid;

  task automatic reset_stats();
    n_valid = 0; n_err = 0; n_rise = 0; n_fall = 0; n_strobe = 0;
    n_unlocked = 0; n_nobypass = 0; valid_since_err = 0;
  endtask

  // Called at each falling edge: tallies strobes and checks every period_meas update.
  task automatic sample();
    int e;
    if (period_valid === 1'b1) begin
      n_valid++;
      valid_since_err++;
      if (check_meas) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL period_valid_unexpected meas=%0d required=no_strobe", period_meas);
        end else begin
          e = exp_q.pop_front();
          if (period_meas !== PW'(e)) begin
            failures++;
            $display("FAIL period_meas got=%0d required=%0d", period_meas, e);
          end
        end
      end
    end
    if (tick_rise === 1'b1) n_rise++;
    if (tick_fall === 1'b1) n_fall++;
    if (period_error === 1'b1) begin
      n_err++;
      valid_since_err = 0;
    end
    if ((tick_rise | tick_fall | period_valid | period_error) !== 1'b0) n_strobe++;
    if (locked !== 1'b1) n_unlocked++;
    if (bypass !== 1'b1) n_nobypass++;
    if (locked === 1'b1 && prev_locked === 1'b0) begin
      lock_valids = valid_since_err;
      lock_after_valid = prev_valid;
    end
    if (locked === 1'b0 && prev_locked === 1'b1) lock_fall_err = period_error;
    prev_locked = locked;
    prev_valid = period_valid;
  endtask

  task automatic step(input logic d);
    @(negedge clock_in);
    sample();
    div_clk_in = d;
  endtask

  task automatic run_period(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
    exp_q.push_back(hi + lo);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    expected_period = 8'd8;
    #12;
    checks++;
    if ({tick_rise, tick_fall, period_valid, locked, period_error, bypass} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {tick_rise, tick_fall, period_valid, locked, period_error, bypass});
    end
    checks++;
    if (period_meas !== 8'd0) begin
      failures++; $display("FAIL reset_period_meas got=%0d required=0", period_meas);
    end
    checks++;
    if (rise_count !== 32'd0) begin
      failures++; $display("FAIL reset_rise_count got=%0d required=0", rise_count);
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    prev_locked = 1'b0;
    prev_valid = 1'b0;
    repeat (6) step(1'b0);
  endtask

  task automatic test_nominal_lock();
    reset_stats();
    lock_valids = -1;
    lock_after_valid = 1'b0;
    repeat (8) run_period(4, 4);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL nominal_locked got=%b required=1", locked); end
    checks++;
    if (lock_valids !== 4) begin failures++; $display("FAIL nominal_lock_valids got=%0d required=4", lock_valids); end
    checks++;
    if (lock_after_valid !== 1'b1) begin
      failures++; $display("FAIL nominal_lock_timing got=%b required=1", lock_after_valid);
    end
    checks++;
    if (rise_count !== 32'd8) begin failures++; $display("FAIL nominal_rise_count got=%0d required=8", rise_count); end
    checks++;
    if (n_rise !== 8 || n_fall !== 8) begin
      failures++; $display("FAIL nominal_ticks rise=%0d fall=%0d required=8/8", n_rise, n_fall);
    end
    checks++;
    if (n_err !== 0) begin failures++; $display("FAIL nominal_errors got=%0d required=0", n_err); end
  endtask

  task automatic test_tolerance();
    int his[3] = '{3, 4, 3};
    int los[3] = '{4, 4, 3};
    expected_period = 8'd7;
    reset_stats();
    for (int i = 0; i < 9; i++) run_period(his[i % 3], los[i % 3]);
    checks++;
    if (n_err !== 0 || n_unlocked !== 0) begin
      failures++; $display("FAIL tolerance_hold errors=%0d unlocked_cycles=%0d required=0/0", n_err, n_unlocked);
    end
    reset_stats();
    lock_valids = -1;
    lock_fall_err = 1'b0;
    run_period(5, 5);
    repeat (6) run_period(3, 4);
    checks++;
    if (n_err !== 1) begin failures++; $display("FAIL tolerance_error_count got=%0d required=1", n_err); end
    checks++;
    if (lock_fall_err !== 1'b1) begin
      failures++; $display("FAIL tolerance_unlock_with_error got=%b required=1", lock_fall_err);
    end
    checks++;
    if (lock_valids !== 4 || locked !== 1'b1) begin
      failures++; $display("FAIL tolerance_relock valids=%0d locked=%b required=4/1", lock_valids, locked);
    end
  endtask

  task automatic test_timeout();
    reset_stats();
    repeat (3) step(1'b1);
    repeat (300) step(1'b0);
    checks++;
    if (n_err !== 1) begin failures++; $display("FAIL timeout_error_count got=%0d required=1", n_err); end
    checks++;
    if (locked !== 1'b0 || n_valid !== 1) begin
      failures++; $display("FAIL timeout_state locked=%b valids=%0d required=0/1", locked, n_valid);
    end
    exp_q.delete();
    reset_stats();
    run_period(3, 4);
    checks++;
    if (n_valid !== 0) begin failures++; $display("FAIL timeout_first_rise valids=%0d required=0", n_valid); end
    run_period(3, 4);
    checks++;
    if (n_valid !== 1) begin failures++; $display("FAIL timeout_second_rise valids=%0d required=1", n_valid); end
  endtask

  task automatic test_bypass();
    expected_period = 8'd1;
    repeat (4) step(1'b0);
    reset_stats();
    repeat (6) run_period(1, 1);
    repeat (4) run_period(2, 2);
    repeat (4) step(1'b0);
    exp_q.delete();
    checks++;
    if (n_strobe !== 0 || n_nobypass !== 0) begin
      failures++; $display("FAIL bypass_quiet strobes=%0d nobypass_cycles=%0d required=0/0", n_strobe, n_nobypass);
    end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL bypass_locked got=%b required=0", locked); end
    expected_period = 8'd4;
    step(1'b0);
    checks++;
    if (bypass !== 1'b1) begin failures++; $display("FAIL bypass_exit_cycle1 got=%b required=1", bypass); end
    step(1'b0);
    checks++;
    if (bypass !== 1'b0) begin failures++; $display("FAIL bypass_exit_cycle2 got=%b required=0", bypass); end
    reset_stats();
    lock_valids = -1;
    repeat (7) run_period(2, 2);
    checks++;
    if (locked !== 1'b1 || lock_valids !== 4 || n_err !== 0) begin
      failures++;
      $display("FAIL bypass_relock locked=%b valids=%0d errors=%0d required=1/4/0", locked, lock_valids, n_err);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic t1, t2, t3;
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL midreset_precondition locked=%b required=1", locked); end
    #2;
    reset_n = 1'b0;
    div_clk_in = 1'b0;
    #1;
    checks++;
    if ({tick_rise, tick_fall, period_valid, locked, period_error, bypass} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_flags got=%b required=000000",
               {tick_rise, tick_fall, period_valid, locked, period_error, bypass});
    end
    checks++;
    if (period_meas !== 8'd0 || rise_count !== 32'd0) begin
      failures++; $display("FAIL midreset_values meas=%0d rise_count=%0d required=0/0", period_meas, rise_count);
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    exp_q.delete();
    check_meas = 1'b0;
    prev_locked = 1'b0;
    prev_valid = 1'b0;
    repeat (5) step(1'b0);
    step(1'b1);
    step(1'b1); t1 = tick_rise;
    step(1'b1); t2 = tick_rise;
    step(1'b0); t3 = tick_rise;
    checks++;
    if ({t1, t2, t3} !== 3'b001) begin
      failures++; $display("FAIL midreset_tick_latency got=%b required=001", {t1, t2, t3});
    end
  endtask

  task automatic test_rise_count_wrap();
    repeat (6) step(1'b0);
    force dut.rise_count = 32'hFFFF_FFFE;
    step(1'b0);
    release dut.rise_count;
    step(1'b0);
    checks++;
    if (rise_count !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL wrap_preload got=%h required=fffffffe", rise_count);
    end
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    checks++;
    if (tick_rise !== 1'b1 || rise_count !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_first tick=%b count=%h required=1/ffffffff", tick_rise, rise_count);
    end
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    checks++;
    if (tick_rise !== 1'b1 || rise_count !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_second tick=%b count=%h required=1/00000000", tick_rise, rise_count);
    end
  endtask

  initial begin
    reset_stats();
    lock_valids = -1;
    lock_after_valid = 1'b0;
    lock_fall_err = 1'b0;
    prev_locked = 1'b0;
    prev_valid = 1'b0;
    test_reset();
    test_nominal_lock();
    test_tolerance();
    test_timeout();
    test_bypass();
    test_reset_mid_lock();
    test_rise_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
